// File: rtl/console_outq.sv
// console_outq: byte queue and TAB expander between the System console output and the
// text-screen receive state machine.
//
// Buffers System bytes while the screen is busy (newline/scroll/clear), paces delivery
// to out_ready with one byte every two cycles at most, and expands TAB into spaces up to
// the next tab stop using a column counter that tracks the screen cursor.
//
// Ports:
//   coreclk    in   core clock
//   rst        in   synchronous reset, active-low
//   in_wr      in   System byte strobe, one byte per high cycle
//   in_data    in   System byte
//   in_full    out  FIFO holds 2^DEPTH_LOG2 bytes; backpressure to System
//   overflow   out  sticky: a write arrived while full; cleared only by reset
//   out_ready  in   screen state machine is idle and can take a byte
//   out_wr     out  one-cycle byte strobe to the screen
//   out_data   out  byte to the screen, valid while out_wr=1
module console_outq #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned COLS       = 80,
   parameter int unsigned TABSTOP    = 8
) (
   input  logic       coreclk,
   input  logic       rst,
   input  logic       in_wr,
   input  logic [7:0] in_data,
   output logic       in_full,
   output logic       overflow,
   input  logic       out_ready,
   output logic       out_wr,
   output logic [7:0] out_data
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] TAB_MASK = COL_W'(TABSTOP - 1);
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {S_IDLE, S_GAP} state_t;

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [COL_W-1:0]      r_col;
   state_t                r_state;
   logic                  r_out_wr;
   logic [7:0]            r_out_data;
   logic                  r_overflow;

   state_t                w_state_next;
   logic [COL_W-1:0]      w_col_next;
   logic                  w_full;
   logic                  w_push;
   logic                  w_emit;
   logic                  w_pop;
   logic                  w_tab_last;
   logic [7:0]            w_head;
   logic [7:0]            w_emit_byte;

   assign w_full = (r_count == COUNT_FULL);
   assign w_push = in_wr && !w_full;
   assign w_head = r_mem[r_rptr];
   // The space about to be emitted lands on the last column before a tab stop.
   assign w_tab_last = ((r_col + COL_W'(1)) & TAB_MASK) == '0;

   // State register
   always_ff @(posedge coreclk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (r_count != '0 && out_ready) w_state_next = S_GAP;
         S_GAP:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode: what is emitted this cycle and whether the head leaves the FIFO.
   always_comb begin
      w_emit      = 1'b0;
      w_pop       = 1'b0;
      w_emit_byte = w_head;
      if (r_state == S_IDLE && r_count != '0 && out_ready) begin
         w_emit = 1'b1;
         if (w_head == 8'h09) begin
            // A tab stays at the head until its final space goes out.
            w_emit_byte = 8'h20;
            w_pop       = w_tab_last;
         end else begin
            w_pop = 1'b1;
         end
      end
   end

   // Column tracking mirrors the screen cursor x.
   always_comb begin
      w_col_next = r_col;
      if (w_emit) begin
         case (w_emit_byte)
            8'h0A, 8'h0D, 8'h0C: w_col_next = '0;
            8'h08:               if (r_col != '0) w_col_next = r_col - COL_W'(1);
            default:             w_col_next = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
         endcase
      end
   end

   always_ff @(posedge coreclk) begin
      if (!rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_col      <= '0;
         r_out_wr   <= 1'b0;
         r_out_data <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         r_out_wr <= w_emit;
         if (w_emit) r_out_data <= w_emit_byte;
         r_col <= w_col_next;
         if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
         // A write while full is dropped even if a pop frees space this same cycle.
         if (in_wr && w_full) r_overflow <= 1'b1;
         if (w_push && !w_pop) begin
            r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
         end
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge coreclk) begin
      if (rst && w_push) r_mem[r_wptr] <= in_data;
   end

   assign in_full  = w_full;
   assign overflow = r_overflow;
   assign out_wr   = r_out_wr;
   assign out_data = r_out_data;

endmodule

// File: tb/tb_console_outq.sv
// Self-checking bench for console_outq: table-driven single-byte vectors, hand-written
// multi-cycle sequences, and a randomized stream checked against a behavioural model.
module tb_console_outq;

   localparam int unsigned COLS    = 80;
   localparam int unsigned TABSTOP = 8;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0] din;
      int         n;
      logic [7:0] ob;
   } vec_t;

   logic       coreclk;
   logic       rst;
   logic       in_wr;
   logic [7:0] in_data;
   logic       in_full;
   logic       overflow;
   logic       out_ready;
   logic       out_wr;
   logic [7:0] out_data;

   int   n_vec;
   int   n_err;
   bq_t  cap;
   logic prev_wr;

   console_outq #(
      .DEPTH_LOG2 (4),
      .COLS       (COLS),
      .TABSTOP    (TABSTOP)
   ) dut (
      .coreclk   (coreclk),
      .rst       (rst),
      .in_wr     (in_wr),
      .in_data   (in_data),
      .in_full   (in_full),
      .overflow  (overflow),
      .out_ready (out_ready),
      .out_wr    (out_wr),
      .out_data  (out_data)
   );

   initial coreclk = 1'b0;
   always #5 coreclk = ~coreclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Capture every emitted byte; strobes must never be back to back.
   initial prev_wr = 1'b0;
   always @(negedge coreclk) begin
      if (rst && out_wr) begin
         cap.push_back(out_data);
         check("no_back_to_back", {31'b0, prev_wr}, 32'd0);
      end
      prev_wr = rst && out_wr;
   end

   // Reference: emitted stream from the accepted byte stream and the cursor rules.
   function automatic void model(input bq_t in_q, inout int col, output bq_t out_q);
      out_q = {};
      foreach (in_q[i]) begin
         if (in_q[i] == 8'h09) begin
            int n;
            n = TABSTOP - (col % TABSTOP);
            repeat (n) out_q.push_back(8'h20);
            col = (col + n) % COLS;
         end else begin
            out_q.push_back(in_q[i]);
            case (in_q[i])
               8'h0A, 8'h0D, 8'h0C: col = 0;
               8'h08:               if (col > 0) col--;
               default:             col = (col + 1) % COLS;
            endcase
         end
      end
   endfunction

   // All tasks start and end at #1 after a rising edge.
   task automatic do_reset();
      rst   = 1'b0;
      in_wr = 1'b0;
      repeat (2) @(posedge coreclk);
      #1;
      rst = 1'b1;
      cap.delete();
   endtask

   task automatic push_bytes(input bq_t b);
      foreach (b[i]) begin
         int g;
         g = 0;
         while (in_full && g < 500) begin
            @(posedge coreclk);
            #1;
            g++;
         end
         if (g >= 500) check("push_wait_timeout", {31'b0, in_full}, 32'd0);
         in_wr   = 1'b1;
         in_data = b[i];
         @(posedge coreclk);
         #1;
         in_wr = 1'b0;
      end
   endtask

   task automatic wait_outs(input int n, input int budget);
      int cyc;
      cyc = 0;
      while (cap.size() < n && cyc < budget) begin
         @(posedge coreclk);
         #1;
         cyc++;
      end
      repeat (6) @(posedge coreclk);
      #1;
   endtask

   task automatic cmp_q(input string name, input bq_t exp);
      check({name, "_len"}, 32'(cap.size()), 32'(exp.size()));
      foreach (exp[i]) begin
         check($sformatf("%s[%0d]", name, i),
               (i < cap.size()) ? {24'b0, cap[i]} : 32'hDEAD, {24'b0, exp[i]});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[12];
      bq_t  q;
      bq_t  exp;
      int   col;

      n_vec     = 0;
      n_err     = 0;
      in_data   = 8'h00;
      out_ready = 1'b1;

      // Expected counts/bytes with the column starting at 0 after reset.
      vt[0]  = '{8'h41, 1, 8'h41};   // col 1
      vt[1]  = '{8'h09, 7, 8'h20};   // col 8
      vt[2]  = '{8'h08, 1, 8'h08};   // col 7
      vt[3]  = '{8'h09, 1, 8'h20};   // col 8
      vt[4]  = '{8'h0D, 1, 8'h0D};   // col 0
      vt[5]  = '{8'h09, 8, 8'h20};   // col 8
      vt[6]  = '{8'h0A, 1, 8'h0A};   // col 0
      vt[7]  = '{8'h00, 1, 8'h00};   // col 1
      vt[8]  = '{8'hFF, 1, 8'hFF};   // col 2
      vt[9]  = '{8'h0C, 1, 8'h0C};   // col 0
      vt[10] = '{8'h08, 1, 8'h08};   // col stays 0
      vt[11] = '{8'h09, 8, 8'h20};   // col 8

      // Reset state
      do_reset();
      check("rst_out_wr",   {31'b0, out_wr},   32'd0);
      check("rst_out_data", {24'b0, out_data}, 32'h00);
      check("rst_in_full",  {31'b0, in_full},  32'd0);
      check("rst_overflow", {31'b0, overflow}, 32'd0);

      // "AB": in_wr raised just after edge N; strobes after edges N+2 and N+4.
      in_wr = 1'b1; in_data = 8'h41;
      @(posedge coreclk); #1;                          // N+1
      in_wr = 1'b1; in_data = 8'h42;
      check("ab_n1_out_wr", {31'b0, out_wr}, 32'd0);
      @(posedge coreclk); #1;                          // N+2
      in_wr = 1'b0;
      check("ab_n2_out_wr", {31'b0, out_wr}, 32'd1);
      check("ab_n2_data",   {24'b0, out_data}, 32'h41);
      @(posedge coreclk); #1;                          // N+3
      check("ab_n3_out_wr", {31'b0, out_wr}, 32'd0);
      @(posedge coreclk); #1;                          // N+4
      check("ab_n4_out_wr", {31'b0, out_wr}, 32'd1);
      check("ab_n4_data",   {24'b0, out_data}, 32'h42);
      check("ab_in_full",   {31'b0, in_full},  32'd0);
      check("ab_overflow",  {31'b0, overflow}, 32'd0);

      // Fill with out_ready low, then overflow on the 17th byte.
      do_reset();
      out_ready = 1'b0;
      q = {};
      for (int i = 0; i < 16; i++) q.push_back(8'(8'h30 + i));
      push_bytes(q);
      check("fill_in_full", {31'b0, in_full}, 32'd1);
      check("fill_overflow_pre", {31'b0, overflow}, 32'd0);
      in_wr = 1'b1; in_data = 8'h40;
      @(posedge coreclk); #1;
      in_wr = 1'b0;
      check("ovf_overflow", {31'b0, overflow}, 32'd1);
      out_ready = 1'b1;
      @(posedge coreclk); #1;
      check("ovf_in_full_after_pop", {31'b0, in_full}, 32'd0);
      wait_outs(16, 100);
      col = 0;
      model(q, col, exp);
      cmp_q("ovf_drain", exp);
      check("ovf_sticky", {31'b0, overflow}, 32'd1);

      // Table vectors: one byte each, checked against hand-derived output.
      do_reset();
      for (int v = 0; v < 12; v++) begin
         cap.delete();
         q = {vt[v].din};
         push_bytes(q);
         wait_outs(vt[v].n, 4 * vt[v].n + 10);
         exp = {};
         repeat (vt[v].n) exp.push_back(vt[v].ob);
         cmp_q($sformatf("vec%0d", v), exp);
      end

      // A, TAB, B, then TAB again to show col ended at 9 (7 spaces to 16).
      do_reset();
      push_bytes('{8'h41, 8'h09, 8'h42, 8'h09});
      wait_outs(16, 100);
      exp = {8'h41};
      repeat (7) exp.push_back(8'h20);
      exp.push_back(8'h42);
      repeat (7) exp.push_back(8'h20);
      cmp_q("tab_mid", exp);

      // 79 'A' then TAB at the last column (one space, wraps), then TAB at col 0.
      do_reset();
      q = {};
      repeat (79) q.push_back(8'h41);
      q.push_back(8'h09);
      q.push_back(8'h09);
      push_bytes(q);
      wait_outs(88, 400);
      exp = {};
      repeat (79) exp.push_back(8'h41);
      repeat (9) exp.push_back(8'h20);
      cmp_q("tab_wrap", exp);

      // Backspace and CR bring col back to 0 before the tab.
      do_reset();
      push_bytes('{8'h41, 8'h41, 8'h08, 8'h0D, 8'h09});
      wait_outs(12, 100);
      exp = {8'h41, 8'h41, 8'h08, 8'h0D};
      repeat (8) exp.push_back(8'h20);
      cmp_q("bs_cr_tab", exp);

      // Reset in the middle of a tab with bytes queued behind it.
      do_reset();
      push_bytes('{8'h09, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55});
      begin
         int g;
         g = 0;
         while (cap.size() < 5 && g < 100) begin
            @(negedge coreclk);
            g++;
         end
      end
      check("midtab_spaces_before_rst", 32'(cap.size()), 32'd5);
      rst = 1'b0;
      @(posedge coreclk); #1;
      check("midtab_out_wr",   {31'b0, out_wr},   32'd0);
      check("midtab_in_full",  {31'b0, in_full},  32'd0);
      check("midtab_overflow", {31'b0, overflow}, 32'd0);
      rst = 1'b1;
      cap.delete();
      in_wr = 1'b1; in_data = 8'h5A;
      @(posedge coreclk); #1;
      in_wr = 1'b0;
      check("midtab_lat_n1", {31'b0, out_wr}, 32'd0);
      @(posedge coreclk); #1;
      check("midtab_lat_n2", {31'b0, out_wr}, 32'd1);
      check("midtab_lat_data", {24'b0, out_data}, 32'h5A);
      push_bytes('{8'h09});
      wait_outs(8, 100);
      // col was cleared: Z moves it to 1, so the tab gives 7 spaces and nothing queued remains.
      exp = {8'h5A};
      repeat (7) exp.push_back(8'h20);
      cmp_q("midtab_after", exp);

      // Randomized stream with random out_ready against the model.
      do_reset();
      q = {};
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    q.push_back(8'h09);
            2:       q.push_back(8'h08);
            3:       q.push_back(8'h0D);
            4:       q.push_back(8'h0A);
            default: q.push_back(8'($urandom_range(0, 255)));
         endcase
      end
      foreach (q[i]) begin
         int g;
         g = 0;
         while (g < 1000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_full && $urandom_range(0, 1) == 1) begin
               in_wr   = 1'b1;
               in_data = q[i];
               @(posedge coreclk); #1;
               in_wr = 1'b0;
               break;
            end
            @(posedge coreclk); #1;
            g++;
         end
         if (g >= 1000) check("rand_push_timeout", {31'b0, in_full}, 32'd0);
      end
      out_ready = 1'b1;
      col = 0;
      model(q, col, exp);
      wait_outs(exp.size(), 20 * exp.size() + 100);
      cmp_q("rand", exp);
      check("rand_overflow", {31'b0, overflow}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
